// File: rtl/run_dump_ctrl_if.sv
// Dump stream bundle between run_dump_ctrl and its consumer.
// Latency: none (wires only).
// Backpressure: master holds dump_data/dump_idx stable while dump_valid && !dump_ready.
//
// Signals:
//   dump_valid  master->slave  beat valid
//   dump_ready  slave->master  consumer ready
//   dump_data   master->slave  beat payload (PC on idx 0, then x0..x(NREG-1))
//   dump_idx    master->slave  beat index, 0 = PC, k = register k-1
interface run_dump_ctrl_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) ();
   logic                    dump_valid;
   logic                    dump_ready;
   logic [XLEN-1:0]         dump_data;
   logic [$clog2(NREG):0]   dump_idx;

   modport master (
      output dump_valid,
      output dump_data,
      output dump_idx,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_data,
      input  dump_idx,
      output dump_ready
   );
endinterface

// File: rtl/run_dump_ctrl.sv
// Run-control and state-dump controller: gates an RV32 core for N instructions or to a PC breakpoint, then streams PC + register file.
// Latency: start -> RUN next cycle; halt -> CAP next cycle -> first beat the cycle after; done one cycle after the final beat.
// Backpressure: dump beats wait on dump_ready; payload and index hold while stalled.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         one-cycle pulse, begins a run (ignored unless IDLE)
//   i_mode          0 = COUNT, 1 = BREAK (sampled with i_start)
//   i_inst_limit    instruction limit, 0 = none in BREAK / immediate dump in COUNT
//   i_bp_addr       breakpoint PC (sampled with i_start)
//   i_abort         force halt while running
//   i_pc            core's current PC
//   o_core_en       core enable, one retired instruction per high cycle
//   o_rf_raddr      register-file read address (combinational read)
//   i_rf_rdata      register-file read data
//   o_busy          controller not idle
//   o_bp_hit        last run halted on the breakpoint
//   o_done          one-cycle pulse after the final beat is accepted
//   o_retired       instructions retired in the current/last run, saturating
//   dump            dump stream (master side)
module run_dump_ctrl #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 16,
   localparam int AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic [CNT_W-1:0]  i_inst_limit,
   input  logic [XLEN-1:0]   i_bp_addr,
   input  logic              i_abort,
   input  logic [XLEN-1:0]   i_pc,
   output logic              o_core_en,
   output logic [AW-1:0]     o_rf_raddr,
   input  logic [XLEN-1:0]   i_rf_rdata,
   output logic              o_busy,
   output logic              o_bp_hit,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_retired,
   run_dump_ctrl_if.master   dump
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_CAP  = 2'd2,
      S_DUMP = 2'd3
   } state_t;

   localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG);

   state_t            r_state;
   logic              r_mode;
   logic [CNT_W-1:0]  r_limit;
   logic [XLEN-1:0]   r_bp;
   logic [CNT_W-1:0]  r_retired;
   logic              r_bp_hit;
   logic              r_done;
   logic              r_cnt_stop;
   logic [XLEN-1:0]   r_dat;
   logic [AW:0]       r_idx;
   logic [AW-1:0]     r_rp;

   logic              w_limit_on;
   logic              w_bp_match;
   logic              w_cnt_hit;
   logic              w_halt;
   logic [CNT_W:0]    w_ret_inc;
   logic              w_last;
   logic              w_fire;
   logic              w_valid;

   assign w_limit_on = (r_limit != '0);
   assign w_bp_match = r_mode && (i_pc == r_bp);
   assign w_cnt_hit  = w_limit_on && (r_retired == r_limit);
   assign w_halt     = i_abort || w_bp_match || w_cnt_hit;

   // Extra bit catches the wrap so the counter can saturate at all-ones.
   assign w_ret_inc  = {1'b0, r_retired} + {{CNT_W{1'b0}}, 1'b1};

   // The instruction retiring this cycle is the last one allowed: leave RUN
   // now so core_en is high for exactly `limit` cycles and CAP follows directly.
   assign w_last     = w_limit_on && (w_ret_inc == {1'b0, r_limit});

   assign w_valid    = (r_state == S_DUMP);
   assign w_fire     = w_valid && dump.dump_ready;

   assign o_core_en  = (r_state == S_RUN) && !w_halt;
   assign o_busy     = (r_state != S_IDLE);
   assign o_bp_hit   = r_bp_hit;
   assign o_done     = r_done;
   assign o_retired  = r_retired;
   assign o_rf_raddr = r_rp;

   assign dump.dump_valid = w_valid;
   assign dump.dump_data  = r_dat;
   assign dump.dump_idx   = r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mode     <= 1'b0;
         r_limit    <= '0;
         r_bp       <= '0;
         r_retired  <= '0;
         r_bp_hit   <= 1'b0;
         r_done     <= 1'b0;
         r_cnt_stop <= 1'b0;
         r_dat      <= '0;
         r_idx      <= '0;
         r_rp       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_mode     <= i_mode;
                  r_limit    <= i_inst_limit;
                  r_bp       <= i_bp_addr;
                  r_retired  <= '0;
                  r_bp_hit   <= 1'b0;
                  r_cnt_stop <= 1'b0;
                  if (!i_mode && (i_inst_limit == '0))
                     r_state <= S_CAP;
                  else
                     r_state <= S_RUN;
               end
            end

            S_RUN: begin
               if (w_halt) begin
                  // Abort outranks the breakpoint; a pure count halt never sets bp_hit.
                  r_bp_hit <= !i_abort && w_bp_match;
                  r_state  <= S_CAP;
               end else begin
                  if (!w_ret_inc[CNT_W])
                     r_retired <= w_ret_inc[CNT_W-1:0];
                  if (w_last) begin
                     r_cnt_stop <= 1'b1;
                     r_state    <= S_CAP;
                  end
               end
            end

            S_CAP: begin
               // After a count stop the core sits at the next PC now; if that
               // PC is the breakpoint it coincides with the count and wins.
               if (r_cnt_stop && w_bp_match)
                  r_bp_hit <= 1'b1;
               r_dat   <= i_pc;
               r_idx   <= '0;
               r_rp    <= '0;
               r_state <= S_DUMP;
            end

            S_DUMP: begin
               if (w_fire) begin
                  if (r_idx == LAST_IDX) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_dat <= i_rf_rdata;
                     r_idx <= r_idx + 1'b1;
                     r_rp  <= r_rp + 1'b1;
                  end
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Directed bench for run_dump_ctrl with a tiny core model (PC += 4 and x1 += 1 per enabled cycle).
// Latency: n/a.
// Backpressure: dump_ready driven per cycle, either held high or randomised.
module tb_run_dump_ctrl;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int CNT_W = 16;
   localparam int AW    = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              mode;
   logic [CNT_W-1:0]  inst_limit;
   logic [XLEN-1:0]   bp_addr;
   logic              abort;
   logic [XLEN-1:0]   pc;
   logic              core_en;
   logic [AW-1:0]     rf_raddr;
   logic [XLEN-1:0]   rf_rdata;
   logic              busy;
   logic              bp_hit;
   logic              done;
   logic [CNT_W-1:0]  retired;

   logic              core_rst;
   logic [XLEN-1:0]   x1;

   run_dump_ctrl_if #(.XLEN(XLEN), .NREG(NREG)) dif ();

   run_dump_ctrl #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (start),
      .i_mode       (mode),
      .i_inst_limit (inst_limit),
      .i_bp_addr    (bp_addr),
      .i_abort      (abort),
      .i_pc         (pc),
      .o_core_en    (core_en),
      .o_rf_raddr   (rf_raddr),
      .i_rf_rdata   (rf_rdata),
      .o_busy       (busy),
      .o_bp_hit     (bp_hit),
      .o_done       (done),
      .o_retired    (retired),
      .dump         (dif)
   );

   always #5 clk = ~clk;

   // Core model: program of repeated `addi x1,x1,1`.
   always @(posedge clk) begin
      if (core_rst) begin
         pc <= '0;
         x1 <= '0;
      end else if (core_en) begin
         pc <= pc + 32'd4;
         x1 <= x1 + 32'd1;
      end
   end

   function automatic logic [31:0] regval(input int k, input logic [31:0] x1v);
      if (k == 0)      return 32'd0;
      else if (k == 1) return x1v;
      else             return 32'hA000_0000 | 32'(k);
   endfunction

   always_comb rf_rdata = regval(int'(rf_raddr), x1);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-run observations.
   int          en_cnt, first_vld, done_cyc, done_cnt, beats, seq_err, stall_err, bp_viol;
   logic [31:0] pc_beat, x1_beat;
   bit          fin, busy_at_done;

   task automatic run(input logic m, input logic [15:0] lim, input logic [31:0] bp,
                      input bit rnd, input int abort_cyc);
      int          cyc;
      bit          stalled;
      logic [31:0] st_dat;
      logic [5:0]  st_idx;
      en_cnt = 0; first_vld = -1; done_cyc = -1; done_cnt = 0; beats = 0;
      seq_err = 0; stall_err = 0; bp_viol = 0; pc_beat = 'x; x1_beat = 'x;
      fin = 0; busy_at_done = 1; stalled = 0; st_dat = '0; st_idx = '0;
      @(negedge clk); core_rst = 1'b1;
      @(negedge clk); core_rst = 1'b0;
      start = 1'b1; mode = m; inst_limit = lim; bp_addr = bp; abort = 1'b0;
      dif.dump_ready = 1'b1;
      cyc = 0;
      while (!fin && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         abort = (cyc == abort_cyc);
         dif.dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (core_en) begin
            en_cnt++;
            if (m && pc == bp) bp_viol++;
         end
         if (stalled && (dif.dump_data !== st_dat || dif.dump_idx !== st_idx)) stall_err++;
         stalled = 0;
         if (dif.dump_valid) begin
            if (first_vld < 0) first_vld = cyc;
            if (dif.dump_ready) begin
               if (int'(dif.dump_idx) != beats) seq_err++;
               else if (beats == 0) pc_beat = dif.dump_data;
               else if (dif.dump_data !== regval(beats - 1, x1)) seq_err++;
               if (beats == 2) x1_beat = dif.dump_data;
               beats++;
            end else begin
               stalled = 1;
               st_dat  = dif.dump_data;
               st_idx  = dif.dump_idx;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
            fin          = 1;
         end
      end
      abort = 1'b0;
      dif.dump_ready = 1'b1;
      chk("run_timeout", 32'(fin), 32'd1);
      repeat (3) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
   endtask

   initial begin
      int  waited;
      bit  reached;
      int  extra_done;
      rst = 1'b1; core_rst = 1'b1; start = 1'b0; mode = 1'b0; inst_limit = '0;
      bp_addr = '0; abort = 1'b0; dif.dump_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_core_en", 32'(core_en), 32'd0);
      chk("rst_valid",   32'(dif.dump_valid), 32'd0);
      chk("rst_data",    dif.dump_data, 32'd0);
      chk("rst_idx",     32'(dif.dump_idx), 32'd0);
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_bp_hit",  32'(bp_hit), 32'd0);
      chk("rst_done",    32'(done), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_raddr",   32'(rf_raddr), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // COUNT 5: PCs 0..0x10 execute, halted PC 0x14, x1 = 5.
      run(1'b0, 16'd5, 32'h0, 1'b0, -1);
      chk("c5_en_cycles", 32'(en_cnt), 32'd5);
      chk("c5_first_vld", 32'(first_vld), 32'd7);
      chk("c5_pc_beat",   pc_beat, 32'h14);
      chk("c5_x1_beat",   x1_beat, 32'd5);
      chk("c5_beats",     32'(beats), 32'd33);
      chk("c5_seq_err",   32'(seq_err), 32'd0);
      chk("c5_done_cnt",  32'(done_cnt), 32'd1);
      chk("c5_done_cyc",  32'(done_cyc), 32'd40);
      chk("c5_busy_done", 32'(busy_at_done), 32'd0);
      chk("c5_retired",   32'(retired), 32'd5);
      chk("c5_bp_hit",    32'(bp_hit), 32'd0);

      // BREAK at 0x10, unbounded: four instructions retire, match in cycle 5.
      run(1'b1, 16'd0, 32'h10, 1'b0, -1);
      chk("bp_en_cycles", 32'(en_cnt), 32'd4);
      chk("bp_en_at_bp",  32'(bp_viol), 32'd0);
      chk("bp_pc_beat",   pc_beat, 32'h10);
      chk("bp_first_vld", 32'(first_vld), 32'd7);
      chk("bp_bp_hit",    32'(bp_hit), 32'd1);
      chk("bp_retired",   32'(retired), 32'd4);
      chk("bp_beats",     32'(beats), 32'd33);

      // BREAK unreachable, limit 8 acts as timeout.
      run(1'b1, 16'd8, 32'h0000_FFF0, 1'b0, -1);
      chk("to_retired",   32'(retired), 32'd8);
      chk("to_bp_hit",    32'(bp_hit), 32'd0);
      chk("to_en_cycles", 32'(en_cnt), 32'd8);
      chk("to_pc_beat",   pc_beat, 32'h20);
      chk("to_first_vld", 32'(first_vld), 32'd10);

      // COUNT 0: straight to capture.
      run(1'b0, 16'd0, 32'h0, 1'b0, -1);
      chk("z_en_cycles", 32'(en_cnt), 32'd0);
      chk("z_first_vld", 32'(first_vld), 32'd2);
      chk("z_retired",   32'(retired), 32'd0);
      chk("z_pc_beat",   pc_beat, 32'h0);
      chk("z_beats",     32'(beats), 32'd33);

      // Random backpressure.
      run(1'b0, 16'd3, 32'h0, 1'b1, -1);
      chk("bk_beats",     32'(beats), 32'd33);
      chk("bk_seq_err",   32'(seq_err), 32'd0);
      chk("bk_stall_err", 32'(stall_err), 32'd0);
      chk("bk_done_cnt",  32'(done_cnt), 32'd1);
      chk("bk_pc_beat",   pc_beat, 32'hC);

      // Abort in RUN cycle 3 of a limit-10 run.
      run(1'b0, 16'd10, 32'h0, 1'b0, 3);
      chk("ab_retired",   32'(retired), 32'd2);
      chk("ab_en_cycles", 32'(en_cnt), 32'd2);
      chk("ab_pc_beat",   pc_beat, 32'h8);
      chk("ab_beats",     32'(beats), 32'd33);
      chk("ab_bp_hit",    32'(bp_hit), 32'd0);

      // Reset mid-DUMP.
      @(negedge clk); core_rst = 1'b1;
      @(negedge clk); core_rst = 1'b0;
      start = 1'b1; mode = 1'b0; inst_limit = 16'd2; dif.dump_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      reached = 0;
      waited  = 0;
      while (!reached && waited < 100) begin
         if (dif.dump_valid && dif.dump_idx == 6'd3) reached = 1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      chk("mr_reach_dump", 32'(reached), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid",   32'(dif.dump_valid), 32'd0);
      chk("mr_data",    dif.dump_data, 32'd0);
      chk("mr_idx",     32'(dif.dump_idx), 32'd0);
      chk("mr_busy",    32'(busy), 32'd0);
      chk("mr_retired", 32'(retired), 32'd0);
      chk("mr_done",    32'(done), 32'd0);
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      extra_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      chk("mr_no_done", 32'(extra_done), 32'd0);

      run(1'b0, 16'd2, 32'h0, 1'b0, -1);
      chk("rs_retired", 32'(retired), 32'd2);
      chk("rs_pc_beat", pc_beat, 32'h8);
      chk("rs_beats",   32'(beats), 32'd33);
      chk("rs_seq_err", 32'(seq_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
